// File: rtl/pipe_hazard_ctrl.sv
// Stall/bubble sequencing for a 5-stage Y86-64 pipeline: post-reset flush, run-time hazard
// handling, sticky halt on a faulting writeback status, and saturating hazard event counters.
module pipe_hazard_ctrl #(
    parameter int INIT_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       M_icode,
    input  logic [2:0]       m_stat,
    input  logic [2:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             set_cc,
    output logic             halted,
    output logic [CNT_W-1:0] loaduse_cnt,
    output logic [CNT_W-1:0] mispred_cnt,
    output logic [CNT_W-1:0] ret_cnt
);

    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPOPQ   = 4'hB;
    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [2:0] SAOK    = 3'd1;

    localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [IW-1:0] INIT_LOAD = IW'(INIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t           state_q;
    logic [IW-1:0]    init_cnt_q;
    logic [CNT_W-1:0] cnt_q [3];

    logic lu, mp, rt, exc, w_bad, rt_only;
    logic [2:0] ev;

    always_comb begin
        lu = ((E_icode == IMRMOVQ) || (E_icode == IPOPQ)) && (E_dstM != RNONE) &&
             ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        mp      = (E_icode == IJXX) && !e_Cnd;
        rt      = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET);
        w_bad   = (W_stat != SAOK);
        exc     = (m_stat != SAOK) || w_bad;
        rt_only = !lu && rt;
        ev      = {rt_only, mp, lu};
    end

    always_comb begin
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        D_bubble = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
        W_stall  = 1'b0;
        set_cc   = 1'b0;
        case (state_q)
            S_RUN: begin
                F_stall  = lu | rt;
                D_stall  = lu;
                D_bubble = mp | rt_only;
                E_bubble = mp | lu;
                M_bubble = exc;
                W_stall  = w_bad;
                set_cc   = (E_icode == IOPQ) && !exc;
            end
            S_HALT: begin
                F_stall  = 1'b1;
                D_stall  = 1'b1;
                D_bubble = 1'b0;
                W_stall  = 1'b1;
            end
            default: ;
        endcase
    end

    assign halted = (state_q == S_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_INIT;
            init_cnt_q <= INIT_LOAD;
        end else begin
            case (state_q)
                S_INIT: begin
                    if (init_cnt_q == '0) state_q <= S_RUN;
                    else                  init_cnt_q <= init_cnt_q - 1'b1;
                end
                S_RUN: begin
                    if (w_bad) state_q <= S_HALT;
                end
                default: state_q <= S_HALT;
            endcase
        end
    end

    // Counter order: 0 = load/use, 1 = mispredict, 2 = ret bubble.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q[gi] <= '0;
                end else if ((state_q == S_RUN) && ev[gi] && (cnt_q[gi] != '1)) begin
                    cnt_q[gi] <= cnt_q[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign loaduse_cnt = cnt_q[0];
    assign mispred_cnt = cnt_q[1];
    assign ret_cnt     = cnt_q[2];

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: flush sequence, each hazard class, halt, counter saturation.
module tb_pipe_hazard_ctrl;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
    logic          e_Cnd;
    logic [2:0]    m_stat, W_stat;
    logic          F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted;
    logic [CW-1:0] loaduse_cnt, mispred_cnt, ret_cnt;
    logic [7:0]    ctl;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_hazard_ctrl #(.INIT_CYCLES(4), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
        .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
        .set_cc(set_cc), .halted(halted),
        .loaduse_cnt(loaduse_cnt), .mispred_cnt(mispred_cnt), .ret_cnt(ret_cnt)
    );

    always #5 clk = ~clk;

    // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted}
    assign ctl = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1;
        d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF;
        e_Cnd = 1'b1; m_stat = 3'd1; W_stat = 3'd1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_idle();
        #3;
        n_checks++;
        if (ctl !== 8'b0011_1000) begin
            n_fail++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 8'b0011_1000);
        end
        n_checks++;
        if ({loaduse_cnt, mispred_cnt, ret_cnt} !== '0) begin
            n_fail++; $display("FAIL reset_cnt got=%0d/%0d/%0d exp=0/0/0", loaduse_cnt, mispred_cnt, ret_cnt);
        end
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (ctl !== 8'b0011_1000) begin
                n_fail++; $display("FAIL init_cycle%0d got=%b exp=%b", i, ctl, 8'b0011_1000);
            end
            tick();
        end
        #1;
        n_checks++;
        if (ctl !== 8'b0000_0000) begin
            n_fail++; $display("FAIL run_idle got=%b exp=%b", ctl, 8'b0);
        end
        $display("reset: flush sequence done, ctl=%b", ctl);
    endtask

    task automatic test_loaduse();
        E_icode = 4'h5; E_dstM = 4'h3; d_srcB = 4'h3;
        #1;
        n_checks++;
        if (ctl !== 8'b1101_0000) begin
            n_fail++; $display("FAIL loaduse_ctl got=%b exp=%b", ctl, 8'b1101_0000);
        end
        tick();
        set_idle();
        n_checks++;
        if (loaduse_cnt !== 8'd1) begin
            n_fail++; $display("FAIL loaduse_cnt got=%0d exp=1", loaduse_cnt);
        end
        $display("loaduse: ctl stall applied, loaduse_cnt=%0d", loaduse_cnt);
    endtask

    task automatic test_mispred();
        E_icode = 4'h7; e_Cnd = 1'b0;
        #1;
        n_checks++;
        if (ctl !== 8'b0011_0000) begin
            n_fail++; $display("FAIL mispred_ctl got=%b exp=%b", ctl, 8'b0011_0000);
        end
        tick();
        set_idle();
        n_checks++;
        if (mispred_cnt !== 8'd1) begin
            n_fail++; $display("FAIL mispred_cnt got=%0d exp=1", mispred_cnt);
        end
        $display("mispred: bubbles applied, mispred_cnt=%0d", mispred_cnt);
    endtask

    task automatic test_ret();
        for (int s = 0; s < 3; s++) begin
            set_idle();
            if (s == 0) D_icode = 4'h9;
            if (s == 1) E_icode = 4'h9;
            if (s == 2) M_icode = 4'h9;
            #1;
            n_checks++;
            if (ctl !== 8'b1010_0000) begin
                n_fail++; $display("FAIL ret_stage%0d got=%b exp=%b", s, ctl, 8'b1010_0000);
            end
            tick();
        end
        set_idle();
        n_checks++;
        if (ret_cnt !== 8'd3) begin
            n_fail++; $display("FAIL ret_cnt got=%0d exp=3", ret_cnt);
        end
        // ret in decode coincident with a load/use: stall wins over the ret bubble
        D_icode = 4'h9; E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
        #1;
        n_checks++;
        if (ctl !== 8'b1101_0000) begin
            n_fail++; $display("FAIL ret_lu_ctl got=%b exp=%b", ctl, 8'b1101_0000);
        end
        tick();
        set_idle();
        n_checks++;
        if ({loaduse_cnt, ret_cnt} !== {8'd2, 8'd3}) begin
            n_fail++; $display("FAIL ret_lu_cnt got=%0d/%0d exp=2/3", loaduse_cnt, ret_cnt);
        end
        $display("ret: three-cycle walk plus lu overlap, ret_cnt=%0d loaduse_cnt=%0d", ret_cnt, loaduse_cnt);
    endtask

    task automatic test_halt();
        E_icode = 4'h6;
        #1;
        n_checks++;
        if (ctl !== 8'b0000_0010) begin
            n_fail++; $display("FAIL opq_setcc got=%b exp=%b", ctl, 8'b0000_0010);
        end
        m_stat = 3'd3;
        #1;
        n_checks++;
        if (ctl !== 8'b0000_1000) begin
            n_fail++; $display("FAIL mstat_exc got=%b exp=%b", ctl, 8'b0000_1000);
        end
        tick();
        W_stat = 3'd3;
        #1;
        n_checks++;
        if (ctl !== 8'b0000_1100) begin
            n_fail++; $display("FAIL wstat_run got=%b exp=%b", ctl, 8'b0000_1100);
        end
        tick();
        set_idle();
        E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (ctl !== 8'b1101_1101) begin
                n_fail++; $display("FAIL halt_hold%0d got=%b exp=%b", i, ctl, 8'b1101_1101);
            end
            tick();
        end
        n_checks++;
        if ({loaduse_cnt, mispred_cnt, ret_cnt} !== {8'd2, 8'd1, 8'd3}) begin
            n_fail++; $display("FAIL halt_cnt_frozen got=%0d/%0d/%0d exp=2/1/3", loaduse_cnt, mispred_cnt, ret_cnt);
        end
        set_idle();
        $display("halt: sticky halt entered, ctl=%b", ctl);
    endtask

    task automatic test_saturate();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        E_icode = 4'h5; E_dstM = 4'h3; d_srcB = 4'h3;
        for (int i = 0; i < (1 << CW) + 5; i++) tick();
        n_checks++;
        if (loaduse_cnt !== 8'hFF) begin
            n_fail++; $display("FAIL loaduse_sat got=%0d exp=255", loaduse_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ctl !== 8'b0011_1000 || {loaduse_cnt, mispred_cnt, ret_cnt} !== '0) begin
            n_fail++; $display("FAIL midrun_reset got=%b cnt=%0d/%0d/%0d exp=%b cnt=0/0/0",
                               ctl, loaduse_cnt, mispred_cnt, ret_cnt, 8'b0011_1000);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        #1;
        n_checks++;
        if (ctl !== 8'b0011_1000 || loaduse_cnt !== 8'd0) begin
            n_fail++; $display("FAIL reinit got=%b cnt=%0d exp=%b cnt=0", ctl, loaduse_cnt, 8'b0011_1000);
        end
        $display("saturate: counter held at max, reset re-entered INIT");
    endtask

    initial begin
        test_reset();
        test_loaduse();
        test_mispred();
        test_ret();
        test_halt();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
